ps2_kbd_rx: RTL and testbench

- Host-side PS/2 keyboard receiver. It is the receiving end of the PS/2 clock/data pair driven by the HPS keyboard emulation (ps2_kbd_clk_out / ps2_kbd_data_out) into the Atari core.
- Filters and synchronises the two lines, then deframes 11-bit PS/2 frames and checks parity.
- Folds the E0/F0 prefix bytes into key events and buffers those events in a small FIFO for the keyboard matrix logic.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_evt_fifo.sv | 71 +++++++
 rtl/ps2_kbd_rx.sv | 214 +++++++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  // Frame deframer states.
  typedef enum logic [1:0] {
    PS2_IDLE   = 2'd0,
    PS2_DATA   = 2'd1,
    PS2_PARITY = 2'd2,
    PS2_STOP   = 2'd3
  } ps2_state_t;

  // Prefix bytes folded into the following key event.
  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_REL = 8'hF0;

  // One decoded key event as stored in the event FIFO.
  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_key_evt_t;

  // PS/2 uses odd parity over the 8 data bits plus the parity bit.
  function automatic logic ps2_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through FIFO of key events; drops pushes when full unless a pop frees a slot.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  ps2_key_evt_t push_data,
  input  logic         pop,
  output ps2_key_evt_t pop_data,
  output logic         full,
  output logic         empty,
  output logic         push_drop
);

  localparam int unsigned AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  ps2_key_evt_t mem_q [DEPTH];
  ps2_key_evt_t mem_d [DEPTH];
  logic         pop_ok;
  logic         push_ok;

  // Status flags from the extra pointer wrap bit.
  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_ok    = pop & ~empty;
    push_ok   = push & (~full | pop_ok);
    push_drop = push & full & ~pop_ok;
    pop_data  = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Next pointer and storage values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // Pointer and storage registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// Host-side PS/2 keyboard receiver: line conditioning, frame deframing, prefix folding, event FIFO.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 57000,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       KEY_VALID,
  input  logic       KEY_READY,
  output logic [7:0] KEY_CODE,
  output logic       KEY_EXT,
  output logic       KEY_REL,
  output logic       PAR_ERR,
  output logic       FRAME_ERR,
  output logic       FIFO_OVF,
  output logic       BUSY
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  // Line conditioning.
  logic                  clk_s1_q, clk_s2_q;
  logic                  dat_s1_q, dat_s2_q;
  logic [FILTER_LEN-1:0] hist_q, hist_d;
  logic                  fclk_q, fclk_d;
  logic                  fall_c;

  // Deframer and prefix state.
  ps2_state_t   state_q, state_d;
  logic [2:0]   bitcnt_q, bitcnt_d;
  logic [7:0]   shreg_q, shreg_d;
  logic         par_ok_q, par_ok_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic         ext_q, ext_d;
  logic         rel_q, rel_d;
  logic         par_err_q, par_err_d;
  logic         frame_err_q, frame_err_d;
  logic         push_q, push_d;
  ps2_key_evt_t evt_q, evt_d;
  logic         ovf_q, ovf_d;
  logic         busy_q, busy_d;

  // FIFO interface.
  ps2_key_evt_t head;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_drop;
  logic         fifo_pop;

  // Clock filter: level changes only after FILTER_LEN agreeing samples.
  always_comb begin
    hist_d = {hist_q[FILTER_LEN-2:0], clk_s2_q};
    fclk_d = fclk_q;
    if (hist_d == '0) begin
      fclk_d = 1'b0;
    end else if (&hist_d) begin
      fclk_d = 1'b1;
    end
    fall_c = fclk_q & ~fclk_d;
  end

  // Frame FSM, timeout watchdog and prefix folding.
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    par_ok_d    = par_ok_q;
    ext_d       = ext_q;
    rel_d       = rel_q;
    par_err_d   = 1'b0;
    frame_err_d = 1'b0;
    push_d      = 1'b0;
    evt_d       = evt_q;
    to_cnt_d    = (state_q == PS2_IDLE || fall_c) ? '0 : to_cnt_q + TO_W'(1);

    if (state_q != PS2_IDLE && !fall_c && to_cnt_q == TO_LAST) begin
      frame_err_d = 1'b1;
      state_d     = PS2_IDLE;
      ext_d       = 1'b0;
      rel_d       = 1'b0;
      to_cnt_d    = '0;
    end else if (fall_c) begin
      case (state_q)
        PS2_IDLE: begin
          if (!dat_s2_q) begin
            state_d  = PS2_DATA;
            bitcnt_d = 3'd0;
          end
        end
        PS2_DATA: begin
          shreg_d  = {dat_s2_q, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = PS2_PARITY;
          end
        end
        PS2_PARITY: begin
          par_ok_d = ps2_parity_ok({dat_s2_q, shreg_q});
          state_d  = PS2_STOP;
        end
        PS2_STOP: begin
          state_d = PS2_IDLE;
          if (!dat_s2_q) begin
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            rel_d       = 1'b0;
          end else if (!par_ok_q) begin
            par_err_d = 1'b1;
            ext_d     = 1'b0;
            rel_d     = 1'b0;
          end else if (shreg_q == PS2_PFX_EXT) begin
            ext_d = 1'b1;
          end else if (shreg_q == PS2_PFX_REL) begin
            rel_d = 1'b1;
          end else begin
            push_d = 1'b1;
            evt_d  = '{ext: ext_q, rel: rel_q, code: shreg_q};
            ext_d  = 1'b0;
            rel_d  = 1'b0;
          end
        end
        default: state_d = PS2_IDLE;
      endcase
    end

    ovf_d  = ovf_q | fifo_drop;
    busy_d = (state_d != PS2_IDLE);
  end

  // All receiver registers; the lines idle high so their history presets to 1.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      hist_q      <= '1;
      fclk_q      <= 1'b1;
      state_q     <= PS2_IDLE;
      bitcnt_q    <= 3'd0;
      shreg_q     <= 8'd0;
      par_ok_q    <= 1'b0;
      to_cnt_q    <= '0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      push_q      <= 1'b0;
      evt_q       <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      clk_s1_q    <= PS2_CLK;
      clk_s2_q    <= clk_s1_q;
      dat_s1_q    <= PS2_DAT;
      dat_s2_q    <= dat_s1_q;
      hist_q      <= hist_d;
      fclk_q      <= fclk_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      par_ok_q    <= par_ok_d;
      to_cnt_q    <= to_cnt_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
      push_q      <= push_d;
      evt_q       <= evt_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
    end
  end

  // Event buffer towards the keyboard matrix logic.
  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .push      (push_q),
    .push_data (evt_q),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .push_drop (fifo_drop)
  );

  // A dropped event can only happen against a full buffer.
  always_comb begin
    assert (!fifo_drop || fifo_full);
  end

  // Output mapping.
  always_comb begin
    fifo_pop  = ~fifo_empty & KEY_READY;
    KEY_VALID = ~fifo_empty;
    KEY_CODE  = head.code;
    KEY_EXT   = head.ext;
    KEY_REL   = head.rel;
    PAR_ERR   = par_err_q;
    FRAME_ERR = frame_err_q;
    FIFO_OVF  = ovf_q;
    BUSY      = busy_q;
  end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: table of single frames plus hand-written corner sequences.
module tb_ps2_kbd_rx;

  localparam int FLEN = 8;
  localparam int TO   = 2000;
  localparam int H    = 20;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic       KEY_VALID;
  logic       KEY_READY;
  logic [7:0] KEY_CODE;
  logic       KEY_EXT;
  logic       KEY_REL;
  logic       PAR_ERR;
  logic       FRAME_ERR;
  logic       FIFO_OVF;
  logic       BUSY;

  int checks   = 0;
  int failures = 0;
  int par_cnt  = 0;
  int frm_cnt  = 0;

  ps2_kbd_rx #(
    .FILTER_LEN  (FLEN),
    .TIMEOUT_CYC (TO),
    .FIFO_DEPTH  (8)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .PS2_CLK   (PS2_CLK),
    .PS2_DAT   (PS2_DAT),
    .KEY_VALID (KEY_VALID),
    .KEY_READY (KEY_READY),
    .KEY_CODE  (KEY_CODE),
    .KEY_EXT   (KEY_EXT),
    .KEY_REL   (KEY_REL),
    .PAR_ERR   (PAR_ERR),
    .FRAME_ERR (FRAME_ERR),
    .FIFO_OVF  (FIFO_OVF),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  // Count error pulse cycles.
  always @(posedge CLK) begin
    if (PAR_ERR === 1'b1) par_cnt++;
    if (FRAME_ERR === 1'b1) frm_cnt++;
  end

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] code;
    bit         bad_par;
    bit         exp_valid;
    logic [7:0] exp_code;
    bit         exp_ext;
    bit         exp_rel;
    int         exp_par;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic logic [10:0] mk(input logic [7:0] c, input bit bad);
    logic p;
    p = (~^c) ^ bad;
    return {1'b1, p, c, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      PS2_DAT = f[i];
      cyc(H);
      PS2_CLK = 1'b0;
      cyc(H);
      PS2_CLK = 1'b1;
      cyc(H);
    end
  endtask

  task automatic send_frame(input logic [7:0] c, input bit bad);
    send_bits(mk(c, bad), 0, 10);
  endtask

  // Stop bit with a one-cycle KEY_READY in the push cycle (push_q high 10 cycles after the low drive).
  task automatic send_frame_pop_at_push(input logic [7:0] c, output logic [7:0] popped);
    logic [10:0] f;
    f = mk(c, 1'b0);
    send_bits(f, 0, 9);
    PS2_DAT = 1'b1;
    cyc(H);
    PS2_CLK = 1'b0;
    cyc(10);
    KEY_READY = 1'b1;
    popped    = KEY_CODE;
    cyc(1);
    KEY_READY = 1'b0;
    cyc(H - 11);
    PS2_CLK = 1'b1;
    cyc(H);
  endtask

  task automatic pop1;
    KEY_READY = 1'b1;
    cyc(1);
    KEY_READY = 1'b0;
  endtask

  vec_t vecs [14];

  initial begin
    int          p0, f0;
    logic [10:0] f;
    logic [7:0]  popped;

    vecs[0]  = '{8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 0};
    vecs[1]  = '{8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    vecs[2]  = '{8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    vecs[3]  = '{8'h74, 1'b0, 1'b1, 8'h74, 1'b1, 1'b1, 0};
    vecs[4]  = '{8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    vecs[5]  = '{8'h1C, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1};
    vecs[6]  = '{8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 0};
    vecs[7]  = '{8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    vecs[8]  = '{8'hE1, 1'b0, 1'b1, 8'hE1, 1'b1, 1'b0, 0};
    vecs[9]  = '{8'hAA, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 0};
    vecs[10] = '{8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    vecs[11] = '{8'hFA, 1'b0, 1'b1, 8'hFA, 1'b0, 1'b1, 0};
    vecs[12] = '{8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    vecs[13] = '{8'h1C, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1};

    RESET_N   = 1'b0;
    PS2_CLK   = 1'b1;
    PS2_DAT   = 1'b1;
    KEY_READY = 1'b0;
    @(posedge CLK);
    #1;
    cyc(3);
    chk("rst_valid", 32'(KEY_VALID), 0);
    chk("rst_code", 32'(KEY_CODE), 0);
    chk("rst_flags", 32'({KEY_EXT, KEY_REL, PAR_ERR, FRAME_ERR, FIFO_OVF, BUSY}), 0);
    RESET_N = 1'b1;
    cyc(3);
    chk("post_rst_valid", 32'(KEY_VALID), 0);
    chk("post_rst_busy", 32'(BUSY), 0);

    // Latency of a single make code: KEY_VALID rises 2 cycles after the stop-bit edge cycle.
    f = mk(8'h1C, 1'b0);
    send_bits(f, 0, 9);
    chk("lat_busy_before_stop", 32'(BUSY), 1);
    PS2_DAT = 1'b1;
    cyc(H);
    PS2_CLK = 1'b0;
    cyc(10);
    chk("lat_valid_early", 32'(KEY_VALID), 0);
    cyc(1);
    chk("lat_valid_on_time", 32'(KEY_VALID), 1);
    chk("lat_code", 32'(KEY_CODE), 32'h1C);
    chk("lat_ext_rel", 32'({KEY_EXT, KEY_REL}), 0);
    cyc(H - 11);
    PS2_CLK = 1'b1;
    cyc(H);
    pop1();
    chk("lat_empty_after_pop", 32'(KEY_VALID), 0);

    // Table of single frames.
    for (int i = 0; i < 14; i++) begin
      p0 = par_cnt;
      f0 = frm_cnt;
      send_frame(vecs[i].code, vecs[i].bad_par);
      chk($sformatf("v%0d_valid", i), 32'(KEY_VALID), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d_par_pulses", i), 32'(par_cnt - p0), 32'(vecs[i].exp_par));
      chk($sformatf("v%0d_frm_pulses", i), 32'(frm_cnt - f0), 0);
      chk($sformatf("v%0d_busy", i), 32'(BUSY), 0);
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d_code", i), 32'(KEY_CODE), 32'(vecs[i].exp_code));
        chk($sformatf("v%0d_ext", i), 32'(KEY_EXT), 32'(vecs[i].exp_ext));
        chk($sformatf("v%0d_rel", i), 32'(KEY_REL), 32'(vecs[i].exp_rel));
        pop1();
        chk($sformatf("v%0d_empty", i), 32'(KEY_VALID), 0);
      end
    end
    // After a parity error the pending E0 is gone.
    send_frame(8'h5A, 1'b0);
    chk("after_par_code", 32'(KEY_CODE), 32'h5A);
    chk("after_par_ext_rel", 32'({KEY_EXT, KEY_REL}), 0);
    pop1();

    // Timeout mid-frame, with a pending F0 that must be cleared.
    send_frame(8'hF0, 1'b0);
    f0 = frm_cnt;
    send_bits(mk(8'h33, 1'b0), 0, 4);
    chk("to_busy_mid", 32'(BUSY), 1);
    cyc(TO + 10);
    chk("to_frm_pulses", 32'(frm_cnt - f0), 1);
    chk("to_busy_after", 32'(BUSY), 0);
    chk("to_no_event", 32'(KEY_VALID), 0);
    send_frame(8'h33, 1'b0);
    chk("to_next_valid", 32'(KEY_VALID), 1);
    chk("to_next_code", 32'(KEY_CODE), 32'h33);
    chk("to_next_rel", 32'(KEY_REL), 0);
    pop1();

    // Reset mid-frame.
    p0 = par_cnt;
    f0 = frm_cnt;
    send_bits(mk(8'h44, 1'b0), 0, 4);
    chk("rmf_busy_mid", 32'(BUSY), 1);
    RESET_N = 1'b0;
    cyc(1);
    RESET_N = 1'b1;
    chk("rmf_busy_after", 32'(BUSY), 0);
    cyc(TO + 10);
    chk("rmf_no_err", 32'((par_cnt - p0) + (frm_cnt - f0)), 0);
    chk("rmf_busy_idle", 32'(BUSY), 0);
    send_frame(8'h44, 1'b0);
    chk("rmf_next_code", 32'({KEY_VALID, KEY_CODE}), 32'h144);
    pop1();

    // Glitch rejection in IDLE and in DATA.
    PS2_DAT = 1'b0;
    PS2_CLK = 1'b0;
    cyc(FLEN - 1);
    PS2_CLK = 1'b1;
    cyc(H);
    chk("glitch_idle_busy", 32'(BUSY), 0);
    PS2_DAT = 1'b1;
    cyc(H);
    f0 = frm_cnt;
    p0 = par_cnt;
    f  = mk(8'h5B, 1'b0);
    send_bits(f, 0, 3);
    PS2_DAT = ~f[4];
    cyc(H);
    PS2_CLK = 1'b0;
    cyc(FLEN - 1);
    PS2_CLK = 1'b1;
    cyc(H);
    send_bits(f, 4, 10);
    chk("glitch_data_code", 32'({KEY_VALID, KEY_CODE}), 32'h15B);
    chk("glitch_data_err", 32'((par_cnt - p0) + (frm_cnt - f0)), 0);
    pop1();

    // Overflow: 8 fit, the 9th is dropped.
    for (int k = 1; k <= 8; k++) send_frame(8'(k), 1'b0);
    chk("ovf_not_yet", 32'(FIFO_OVF), 0);
    send_frame(8'h09, 1'b0);
    chk("ovf_set", 32'(FIFO_OVF), 1);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("ovf_drain_%0d", k), 32'({KEY_VALID, KEY_CODE}), 32'h100 | 32'(k));
      pop1();
    end
    chk("ovf_drained", 32'(KEY_VALID), 0);
    chk("ovf_sticky", 32'(FIFO_OVF), 1);

    // Full FIFO with a pop in the push cycle accepts the new event.
    for (int k = 1; k <= 8; k++) send_frame(8'h10 + 8'(k), 1'b0);
    send_frame_pop_at_push(8'h19, popped);
    chk("fullpop_popped_head", 32'(popped), 32'h11);
    for (int k = 2; k <= 9; k++) begin
      chk($sformatf("fullpop_drain_%0d", k), 32'({KEY_VALID, KEY_CODE}), 32'h110 | 32'(k));
      pop1();
    end
    chk("fullpop_drained", 32'(KEY_VALID), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
